writeback_stage_p: RTL and testbench

- Parametrised successor to the single-mux writeback stage of the pipelined RISC-V core.
- Owns the MEM/WB pipeline register, with stall/flush control.
- Extracts and sign/zero-extends sub-word load data, selects the 4-way result, and gates the register-file write.
- Keeps a retired-instruction counter.
- Sits between the memory stage and the register file / forwarding unit.

---
 rtl/core_pkg.sv | 23 ++
 rtl/load_extend.sv | 62 ++++++
 rtl/writeback_stage_p.sv | 139 +++++++++++++
 tb/tb_writeback_stage_p.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the pipelined RISC-V core.
//   res_src_e  : write-back result select (ResultSrc)
//   load_f3_e  : funct3 load size/sign codes
package core_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_IMM  = 2'b01,
    RES_LOAD = 2'b10,
    RES_PC4  = 2'b11
  } res_src_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_f3_e;

endpackage

// File: rtl/load_extend.sv
// Sub-word load extraction: shifts the aligned memory word right by the byte
// offset, then sign/zero-extends according to funct3, and flags accesses that
// are not naturally aligned.
//   word_i     : raw aligned memory word
//   offset_i   : byte offset inside the word
//   funct3_i   : load size/sign code
//   data_o     : extended load data
//   misalign_o : access not naturally aligned for its size
module load_extend
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]             word_i,
  input  logic [$clog2(XLEN/8)-1:0]   offset_i,
  input  logic [2:0]                  funct3_i,
  output logic [XLEN-1:0]             data_o,
  output logic                        misalign_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = word_i >> {offset_i, 3'b000};

  // Defaults describe a full-width load; this also covers codes that are not
  // legal for the configured XLEN (LD/LWU on RV32, and 3'b111).
  always_comb begin
    data_o     = shifted;
    misalign_o = (offset_i != '0);
    case (funct3_i)
      F3_LB: begin
        data_o     = XLEN'($signed(shifted[7:0]));
        misalign_o = 1'b0;
      end
      F3_LH: begin
        data_o     = XLEN'($signed(shifted[15:0]));
        misalign_o = offset_i[0];
      end
      F3_LW: begin
        data_o     = XLEN'($signed(shifted[31:0]));
        misalign_o = (offset_i[1:0] != 2'b00);
      end
      F3_LBU: begin
        data_o     = XLEN'(shifted[7:0]);
        misalign_o = 1'b0;
      end
      F3_LHU: begin
        data_o     = XLEN'(shifted[15:0]);
        misalign_o = offset_i[0];
      end
      F3_LWU: begin
        if (XLEN == 64) begin
          data_o     = XLEN'(shifted[31:0]);
          misalign_o = (offset_i[1:0] != 2'b00);
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage_p.sv
// Write-back stage: MEM/WB pipeline register with flush/stall, sub-word load
// extension, 4-way result select, qualified register-file write enable and a
// retired-instruction counter.
//   clk, rst        : core clock, synchronous active-high reset
//   *_M             : memory-stage instruction fields
//   Stall_W/Flush_W : hold / squash the WB register
//   Result_W, Rd_W  : write-back data and destination
//   RegWrite_W      : register-file write enable (one pulse per instruction)
//   Valid_W         : WB slot valid
//   Misalign_W      : load in WB is misaligned
//   Instret_W       : retired-instruction count
module writeback_stage_p
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Valid_M,
  input  logic              RegWrite_M,
  input  logic [1:0]        ResultSrc_M,
  input  logic [2:0]        Funct3_M,
  input  logic [XLEN-1:0]   ALUResult_M,
  input  logic [XLEN-1:0]   ReadData_M,
  input  logic [XLEN-1:0]   PCPlus4_M,
  input  logic [XLEN-1:0]   ImmExt_M,
  input  logic [4:0]        Rd_M,
  input  logic              Stall_W,
  input  logic              Flush_W,
  output logic [XLEN-1:0]   Result_W,
  output logic [4:0]        Rd_W,
  output logic              RegWrite_W,
  output logic              Valid_W,
  output logic              Misalign_W,
  output logic [CNT_W-1:0]  Instret_W
);

  localparam int OFF_W = $clog2(XLEN/8);

  logic              valid_q, valid_d;
  logic              regwrite_q, regwrite_d;
  logic [1:0]        src_q, src_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [4:0]        rd_q, rd_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic [XLEN-1:0]   load_data;
  logic              load_mis;

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    src_d      = src_q;
    funct3_d   = funct3_q;
    alu_d      = alu_q;
    rdata_d    = rdata_q;
    pc4_d      = pc4_q;
    imm_d      = imm_q;
    rd_d       = rd_q;
    if (Flush_W) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
    end else if (!Stall_W) begin
      valid_d    = Valid_M;
      regwrite_d = RegWrite_M;
      src_d      = ResultSrc_M;
      funct3_d   = Funct3_M;
      alu_d      = ALUResult_M;
      rdata_d    = ReadData_M;
      pc4_d      = PCPlus4_M;
      imm_d      = ImmExt_M;
      rd_d       = Rd_M;
    end
    // The instruction currently in WB retires when it leaves the stage, which
    // is independent of whether the incoming one is flushed.
    instret_d = instret_q + CNT_W'(valid_q & ~Stall_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= '0;
      funct3_q   <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      instret_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      src_q      <= src_d;
      funct3_q   <= funct3_d;
      alu_q      <= alu_d;
      rdata_q    <= rdata_d;
      pc4_q      <= pc4_d;
      imm_q      <= imm_d;
      rd_q       <= rd_d;
      instret_q  <= instret_d;
    end
  end

  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .word_i     (rdata_q),
    .offset_i   (alu_q[OFF_W-1:0]),
    .funct3_i   (funct3_q),
    .data_o     (load_data),
    .misalign_o (load_mis)
  );

  always_comb begin
    Result_W = alu_q;
    case (src_q)
      RES_ALU:  Result_W = alu_q;
      RES_IMM:  Result_W = imm_q;
      RES_LOAD: Result_W = load_data;
      RES_PC4:  Result_W = pc4_q;
      default:  Result_W = alu_q;
    endcase
  end

  assign Misalign_W = valid_q & (src_q == RES_LOAD) & load_mis;
  // Suppressing the write while stalled leaves only the release cycle to
  // write, so a held instruction writes exactly once.
  assign RegWrite_W = valid_q & regwrite_q & ~Misalign_W & (rd_q != '0) & ~Stall_W;
  assign Valid_W    = valid_q;
  assign Rd_W       = rd_q;
  assign Instret_W  = instret_q;

endmodule

// File: tb/tb_writeback_stage_p.sv
module tb_writeback_stage_p;

  typedef struct {
    logic        v;
    logic        rw;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic [7:0]  cnt;
  } exp_t;

  typedef struct {
    logic [63:0] res;
    logic        mis;
  } exp64_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // RV32 build with a narrow counter so wrap-around is reachable
  logic        Valid_M, RegWrite_M, Stall_W, Flush_W;
  logic [1:0]  ResultSrc_M;
  logic [2:0]  Funct3_M;
  logic [31:0] ALUResult_M, ReadData_M, PCPlus4_M, ImmExt_M;
  logic [4:0]  Rd_M;
  logic [31:0] Result_W;
  logic [4:0]  Rd_W;
  logic        RegWrite_W, Valid_W, Misalign_W;
  logic [7:0]  Instret_W;

  writeback_stage_p #(.XLEN(32), .CNT_W(8)) u_dut32 (
    .clk(clk), .rst(rst), .Valid_M(Valid_M), .RegWrite_M(RegWrite_M),
    .ResultSrc_M(ResultSrc_M), .Funct3_M(Funct3_M), .ALUResult_M(ALUResult_M),
    .ReadData_M(ReadData_M), .PCPlus4_M(PCPlus4_M), .ImmExt_M(ImmExt_M),
    .Rd_M(Rd_M), .Stall_W(Stall_W), .Flush_W(Flush_W), .Result_W(Result_W),
    .Rd_W(Rd_W), .RegWrite_W(RegWrite_W), .Valid_W(Valid_W),
    .Misalign_W(Misalign_W), .Instret_W(Instret_W)
  );

  // RV64 build
  logic        v64, rw64;
  logic [1:0]  src64;
  logic [2:0]  f3_64;
  logic [63:0] alu64, rdat64, pc64, imm64;
  logic [4:0]  rd64;
  logic [63:0] res64_o;
  logic [4:0]  rd64_o;
  logic        rw64_o, v64_o, mis64_o;
  logic [63:0] cnt64_o;

  writeback_stage_p #(.XLEN(64), .CNT_W(64)) u_dut64 (
    .clk(clk), .rst(rst), .Valid_M(v64), .RegWrite_M(rw64),
    .ResultSrc_M(src64), .Funct3_M(f3_64), .ALUResult_M(alu64),
    .ReadData_M(rdat64), .PCPlus4_M(pc64), .ImmExt_M(imm64),
    .Rd_M(rd64), .Stall_W(1'b0), .Flush_W(1'b0), .Result_W(res64_o),
    .Rd_W(rd64_o), .RegWrite_W(rw64_o), .Valid_W(v64_o),
    .Misalign_W(mis64_o), .Instret_W(cnt64_o)
  );

  int checks = 0;
  int errors = 0;
  exp_t   q[$];
  exp64_t q64[$];

  vec_t       wb;
  logic [7:0] cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [1:0] src, input logic [2:0] f3,
                              input logic [31:0] alu, input logic [31:0] rdat,
                              input logic [31:0] pc4, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [31:0] exp_res,
                              input logic exp_mis);
    vec_t t;
    t.v = 1'b1; t.rw = rw; t.src = src; t.f3 = f3; t.alu = alu; t.rdat = rdat;
    t.pc4 = pc4; t.imm = imm; t.rd = rd; t.exp_res = exp_res; t.exp_mis = exp_mis;
    return t;
  endfunction

  function automatic vec_t nop();
    vec_t t;
    t = mk(1'b1, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 32'h0, 1'b0);
    t.v = 1'b0;
    return t;
  endfunction

  // One clock of stimulus: drives M fields and the stall/flush that apply to
  // the instruction currently shown in WB, and queues what WB must show now.
  task automatic cycle(input vec_t m, input logic stall, input logic flush);
    exp_t e;
    @(posedge clk); #1;
    Valid_M = m.v; RegWrite_M = m.rw; ResultSrc_M = m.src; Funct3_M = m.f3;
    ALUResult_M = m.alu; ReadData_M = m.rdat; PCPlus4_M = m.pc4; ImmExt_M = m.imm;
    Rd_M = m.rd; Stall_W = stall; Flush_W = flush;
    if (wb.v) begin
      e.res = wb.exp_res; e.rd = wb.rd; e.mis = wb.exp_mis; e.cnt = cnt;
      e.rw  = wb.rw & ~wb.exp_mis & (wb.rd != 5'd0) & ~stall;
      q.push_back(e);
      if (!stall) cnt++;
    end
    if (flush) wb.v = 1'b0;
    else if (!stall) wb = m;
  endtask

  task automatic cyc64(input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] rdat,
                       input logic [63:0] exp_res, input logic exp_mis);
    exp64_t e;
    @(posedge clk); #1;
    v64 = 1'b1; rw64 = 1'b1; src64 = 2'b10; f3_64 = f3; alu64 = alu; rdat64 = rdat;
    e.res = exp_res; e.mis = exp_mis;
    q64.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (Valid_W) begin
        if (q.size() == 0) begin
          chk("unexpected_valid32", {63'd0, Valid_W}, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("Result_W",   {32'd0, Result_W},   {32'd0, e.res});
          chk("Rd_W",       {59'd0, Rd_W},       {59'd0, e.rd});
          chk("RegWrite_W", {63'd0, RegWrite_W}, {63'd0, e.rw});
          chk("Misalign_W", {63'd0, Misalign_W}, {63'd0, e.mis});
          chk("Instret_W",  {56'd0, Instret_W},  {56'd0, e.cnt});
        end
      end else begin
        chk("idle_RegWrite_W", {63'd0, RegWrite_W}, 64'd0);
        chk("idle_Misalign_W", {63'd0, Misalign_W}, 64'd0);
      end
      if (v64_o) begin
        if (q64.size() == 0) begin
          chk("unexpected_valid64", {63'd0, v64_o}, 64'd0);
        end else begin
          exp64_t e;
          e = q64.pop_front();
          chk("Result_W64",   res64_o, e.res);
          chk("Misalign_W64", {63'd0, mis64_o}, {63'd0, e.mis});
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    wb = nop();
    // Valid instructions presented during reset must not be captured
    Valid_M = 1'b1; RegWrite_M = 1'b1; ResultSrc_M = 2'b00; Funct3_M = 3'b010;
    ALUResult_M = 32'h1111; ReadData_M = 32'h2222; PCPlus4_M = 32'h3333;
    ImmExt_M = 32'h4444; Rd_M = 5'd9; Stall_W = 1'b0; Flush_W = 1'b0;
    v64 = 1'b0; rw64 = 1'b0; src64 = 2'b00; f3_64 = 3'b000;
    alu64 = '0; rdat64 = '0; pc64 = '0; imm64 = '0; rd64 = 5'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_Valid_W",    {63'd0, Valid_W},    64'd0);
    chk("rst_RegWrite_W", {63'd0, RegWrite_W}, 64'd0);
    chk("rst_Misalign_W", {63'd0, Misalign_W}, 64'd0);
    chk("rst_Result_W",   {32'd0, Result_W},   64'd0);
    chk("rst_Rd_W",       {59'd0, Rd_W},       64'd0);
    chk("rst_Instret_W",  {56'd0, Instret_W},  64'd0);
    chk("rst_Instret_W64", cnt64_o, 64'd0);
    Valid_M = 1'b0;
    rst = 1'b0;

    // loads and result-select sources
    cycle(mk(1, 2'b10, 3'b010, 32'h100, 32'hDEADBEEF, 32'h4, 32'h0, 5'd5, 32'hDEADBEEF, 0), 0, 0);
    cycle(mk(1, 2'b10, 3'b000, 32'h103, 32'h80FF7F01, 32'h4, 32'h0, 5'd6, 32'hFFFFFF80, 0), 0, 0);
    cycle(mk(1, 2'b10, 3'b100, 32'h102, 32'h80FF7F01, 32'h4, 32'h0, 5'd6, 32'h000000FF, 0), 0, 0);
    cycle(mk(1, 2'b10, 3'b001, 32'h102, 32'h80FF7F01, 32'h4, 32'h0, 5'd6, 32'hFFFF80FF, 0), 0, 0);
    cycle(mk(1, 2'b10, 3'b101, 32'h100, 32'h80FF7F01, 32'h4, 32'h0, 5'd6, 32'h00007F01, 0), 0, 0);
    cycle(mk(1, 2'b10, 3'b001, 32'h103, 32'h80FF7F01, 32'h4, 32'h0, 5'd6, 32'h00000080, 1), 0, 0);
    cycle(mk(1, 2'b10, 3'b010, 32'h102, 32'h80FF7F01, 32'h4, 32'h0, 5'd6, 32'h000080FF, 1), 0, 0);
    cycle(mk(1, 2'b01, 3'b001, 32'h1233, 32'h0, 32'h4, 32'hABCDE000, 5'd8, 32'hABCDE000, 0), 0, 0);
    cycle(mk(1, 2'b11, 3'b001, 32'h1233, 32'h0, 32'h44, 32'h0, 5'd9, 32'h00000044, 0), 0, 0);
    cycle(mk(1, 2'b00, 3'b000, 32'h55, 32'h0, 32'h4, 32'h0, 5'd0, 32'h00000055, 0), 0, 0);
    cycle(mk(0, 2'b00, 3'b000, 32'h66, 32'h0, 32'h4, 32'h0, 5'd3, 32'h00000066, 0), 0, 0);

    // 3-cycle stall on an ALU op writing x7; M holds the next instruction
    cycle(mk(1, 2'b00, 3'b001, 32'h1233, 32'h0, 32'h4, 32'h0, 5'd7, 32'h00001233, 0), 0, 0);
    for (int i = 0; i < 3; i++)
      cycle(mk(1, 2'b01, 3'b000, 32'h0, 32'h0, 32'h4, 32'h77, 5'd10, 32'h00000077, 0), 1, 0);
    cycle(mk(1, 2'b01, 3'b000, 32'h0, 32'h0, 32'h4, 32'h77, 5'd10, 32'h00000077, 0), 0, 0);

    // flush together with stall: held instruction is dropped, incoming squashed
    cycle(mk(1, 2'b00, 3'b000, 32'h88, 32'h0, 32'h4, 32'h0, 5'd11, 32'h00000088, 0), 1, 1);
    cycle(nop(), 0, 0);
    // flush while WB retires: current one counts, incoming squashed
    cycle(mk(1, 2'b00, 3'b000, 32'h99, 32'h0, 32'h4, 32'h0, 5'd12, 32'h00000099, 0), 0, 0);
    cycle(mk(1, 2'b00, 3'b000, 32'hAA, 32'h0, 32'h4, 32'h0, 5'd13, 32'h000000AA, 0), 0, 1);
    cycle(nop(), 0, 0);

    // enough retirements to wrap the 8-bit counter
    for (int i = 0; i < 260; i++)
      cycle(mk(1, 2'b00, 3'b000, 32'(i), 32'h0, 32'h4, 32'h0, 5'd1, 32'(i), 0), 0, 0);
    cycle(nop(), 0, 0);
    cycle(nop(), 0, 0);
    @(negedge clk);
    chk("final_Instret_W", {56'd0, Instret_W}, {56'd0, cnt});

    // RV64 loads
    cyc64(3'b110, 64'h104, 64'hFFFFFFFF80000000, 64'h00000000FFFFFFFF, 0);
    cyc64(3'b010, 64'h104, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF, 0);
    cyc64(3'b011, 64'h100, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 0);
    cyc64(3'b011, 64'h104, 64'hFFFFFFFF80000000, 64'h00000000FFFFFFFF, 1);
    cyc64(3'b000, 64'h103, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFF80, 0);
    cyc64(3'b110, 64'h100, 64'hFFFFFFFF80000000, 64'h0000000080000000, 0);
    @(posedge clk); #1;
    v64 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("Instret_W64", cnt64_o, 64'd6);
    chk("queue32_drained", 64'(q.size()), 64'd0);
    chk("queue64_drained", 64'(q64.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
